// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the console UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    ARB_STATE_ARB,
    ARB_STATE_OWN
  } arb_state_t;

  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdxW-1:0]    i_ptr,
  output logic [IdxW-1:0]    o_idx,
  output logic               o_found
);

  always_comb begin
    int unsigned w_cand;
    o_idx   = '0;
    o_found = 1'b0;
    // Walk from the farthest offset down so the nearest set bit is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_cand = (int'(i_ptr) + i) % NUM_REQ;
      if (i_req[w_cand]) begin
        o_idx   = IdxW'(w_cand);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte streams with round-robin, line-locked grants.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned          NUM_REQ      = 4,
  parameter int unsigned          DATA_WIDTH   = 8,
  parameter bit                   LINE_LOCK    = 1'b1,
  parameter int unsigned          LOCK_TIMEOUT = 4096,
  parameter logic [DATA_WIDTH-1:0] EOL_CHAR    = EOL_DEFAULT,
  localparam int unsigned         IdxW         = $clog2(NUM_REQ),
  localparam int unsigned         CntW         = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic [IdxW-1:0]               o_owner,
  output logic                          o_locked
);

  arb_state_t            r_state;
  logic [IdxW-1:0]       r_owner;
  logic [IdxW-1:0]       r_ptr;
  logic                  r_locked;
  logic [CntW-1:0]       r_tcnt;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;

  logic [IdxW-1:0]       w_pick_idx;
  logic                  w_pick_found;
  logic                  w_own;
  logic                  w_owner_valid;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic                  w_accept;
  logic                  w_idle;
  logic                  w_release;
  logic [IdxW-1:0]       w_next_ptr;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_own         = (r_state == ARB_STATE_OWN);
  assign w_owner_valid = i_req_valid[r_owner];
  assign w_owner_data  = i_req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept      = w_own && w_owner_valid && !r_tx_valid;
  // Idle cycles only count while the output register is empty, so a slow UART never times out.
  assign w_idle        = w_own && !w_owner_valid && !r_tx_valid;
  assign w_release     = (w_accept && (!LINE_LOCK || (w_owner_data == EOL_CHAR)))
                      || (w_idle && (r_tcnt >= CntW'(LOCK_TIMEOUT - 1)));
  assign w_next_ptr    = (r_owner == IdxW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    o_req_ready = '0;
    if (w_own && !r_tx_valid) begin
      o_req_ready[r_owner] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ARB_STATE_ARB;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_locked   <= 1'b0;
      r_tcnt     <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_accept) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_owner_data;
      end else if (r_tx_valid && i_tx_ready) begin
        r_tx_valid <= 1'b0;
      end

      case (r_state)
        ARB_STATE_ARB: begin
          if (w_pick_found) begin
            r_owner  <= w_pick_idx;
            r_locked <= 1'b1;
            r_tcnt   <= '0;
            r_state  <= ARB_STATE_OWN;
          end
        end
        ARB_STATE_OWN: begin
          if (w_accept) begin
            r_tcnt <= '0;
          end else if (w_idle && (r_tcnt != CntW'(LOCK_TIMEOUT))) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
          if (w_release) begin
            r_state  <= ARB_STATE_ARB;
            r_locked <= 1'b0;
            r_ptr    <= w_next_ptr;
          end
        end
        default: r_state <= ARB_STATE_ARB;
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_owner    = r_owner;
  assign o_locked   = r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, randomly stalling sink, line-level reference model.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int LT  = 16;
  localparam logic [7:0] LF = 8'h0A;

  typedef logic [7:0] byte_t;

  logic             clk;
  logic             rst_n;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    drv_valid;
  logic [NR-1:0]    req_valid_m;
  logic [NR-1:0]    req_valid_nl;
  logic             tx_ready;
  bit               sel;

  logic [NR-1:0] m_ready, nl_ready, ready;
  logic [DW-1:0] m_tx_data, nl_tx_data, tx_data;
  logic          m_tx_valid, nl_tx_valid, tx_valid;
  logic [1:0]    m_owner, nl_owner, owner;
  logic          m_locked, nl_locked, locked;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .LINE_LOCK    (1'b1),
    .LOCK_TIMEOUT (LT),
    .EOL_CHAR     (LF)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_data  (req_data),
    .i_req_valid (req_valid_m),
    .o_req_ready (m_ready),
    .o_tx_data   (m_tx_data),
    .o_tx_valid  (m_tx_valid),
    .i_tx_ready  (tx_ready),
    .o_owner     (m_owner),
    .o_locked    (m_locked)
  );

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .LINE_LOCK    (1'b0),
    .LOCK_TIMEOUT (LT),
    .EOL_CHAR     (LF)
  ) dut_nl (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_data  (req_data),
    .i_req_valid (req_valid_nl),
    .o_req_ready (nl_ready),
    .o_tx_data   (nl_tx_data),
    .o_tx_valid  (nl_tx_valid),
    .i_tx_ready  (tx_ready),
    .o_owner     (nl_owner),
    .o_locked    (nl_locked)
  );

  assign req_valid_m  = sel ? '0 : drv_valid;
  assign req_valid_nl = sel ? drv_valid : '0;
  assign ready        = sel ? nl_ready : m_ready;
  assign tx_data      = sel ? nl_tx_data : m_tx_data;
  assign tx_valid     = sel ? nl_tx_valid : m_tx_valid;
  assign owner        = sel ? nl_owner : m_owner;
  assign locked       = sel ? nl_locked : m_locked;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  byte_t      q[NR][$];
  byte_t      mq[NR][$];
  byte_t      rx[$];
  byte_t      exp_q[$];
  int         owners[$];
  int         total;
  int         bad;
  int         cyc;
  int         rdy_pct;
  logic [NR-1:0] last_acc;
  byte_t      last_acc_byte[NR];
  logic       prev_locked;

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      drv_valid[k]          = (q[k].size() != 0);
      req_data[k*DW +: DW]  = (q[k].size() != 0) ? q[k][0] : 8'h00;
    end
    tx_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
  endtask

  // One clock: sample handshakes mid-cycle, then update requester queues after the edge.
  task automatic step();
    @(negedge clk);
    prev_locked = locked;
    last_acc = drv_valid & ready;
    for (int k = 0; k < NR; k++) if (last_acc[k]) last_acc_byte[k] = q[k][0];
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NR; k++) if (last_acc[k]) void'(q[k].pop_front());
    if (!prev_locked && locked) owners.push_back(int'(owner));
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic snapshot();
    for (int k = 0; k < NR; k++) mq[k] = q[k];
  endtask

  // Expected byte stream: whole lines granted round-robin starting at ptr.
  task automatic build_model(input int ptr, input bit line_lock);
    int    p;
    int    k;
    bit    found;
    byte_t b;
    exp_q.delete();
    p = ptr;
    forever begin
      found = 1'b0;
      k = 0;
      for (int i = 0; i < NR; i++) begin
        if (!found && mq[(p + i) % NR].size() != 0) begin
          k = (p + i) % NR;
          found = 1'b1;
        end
      end
      if (!found) break;
      forever begin
        b = mq[k].pop_front();
        exp_q.push_back(b);
        if (!line_lock || b == LF || mq[k].size() == 0) break;
      end
      p = (k + 1) % NR;
    end
  endtask

  task automatic run_until(input int n, input int budget, output bit timed_out);
    int c = 0;
    while (rx.size() < n && c < budget) begin
      step();
      c++;
    end
    timed_out = (rx.size() < n);
  endtask

  function automatic int first_diff();
    int n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx[i] !== exp_q[i]) return i;
    if (rx.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 1'b0;
    drv_valid = '0;
    req_data = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_ready !== 4'h0) begin bad++; $display("FAIL reset_ready: got %h want 0", m_ready); end
    total++; if (m_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", m_tx_valid); end
    total++; if (m_tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", m_tx_data); end
    total++; if (m_owner !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", m_owner); end
    total++; if (m_locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", m_locked); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic test_hi();
    bit to;
    bit eol_seen = 1'b0;
    int c = 0;
    int d;
    rx.delete();
    q[0] = '{8'h68, 8'h69, 8'h0A};
    snapshot();
    build_model(0, 1'b1);
    drive();
    while (rx.size() < 3 && c < 200) begin
      step();
      c++;
      if (last_acc[0] && last_acc_byte[0] == LF) begin
        eol_seen = 1'b1;
        total++;
        if (m_locked !== 1'b0) begin bad++; $display("FAIL hi_eol_release: locked=%b want 0", m_locked); end
      end
    end
    to = (rx.size() < 3);
    total++; if (to) begin bad++; $display("FAIL hi_timeout: got %0d bytes want 3", rx.size()); end
    total++; if (!eol_seen) begin bad++; $display("FAIL hi_eol_accept: eol_seen=0 want 1"); end
    d = first_diff();
    total++; if (d != -1) begin bad++; $display("FAIL hi_stream: differs at %0d, got %0d bytes want %0d", d, rx.size(), exp_q.size()); end
    repeat (4) step();
  endtask

  task automatic test_two_lines();
    bit to;
    int d;
    rx.delete();
    owners.delete();
    q[1] = '{8'h41, 8'h0A};
    q[2] = '{8'h42, 8'h0A};
    snapshot();
    build_model(1, 1'b1);
    drive();
    run_until(4, 300, to);
    total++; if (to) begin bad++; $display("FAIL two_timeout: got %0d bytes want 4", rx.size()); end
    d = first_diff();
    total++; if (d != -1) begin bad++; $display("FAIL two_stream: differs at %0d, got %0d bytes want %0d", d, rx.size(), exp_q.size()); end
    total++; if (owners.size() != 2) begin bad++; $display("FAIL two_grants: got %0d grants want 2", owners.size()); end
    else begin
      total++; if (owners[0] != 1) begin bad++; $display("FAIL two_first_owner: got %0d want 1", owners[0]); end
      total++; if (owners[1] != 2) begin bad++; $display("FAIL two_second_owner: got %0d want 2", owners[1]); end
    end
    repeat (4) step();
  endtask

  task automatic test_timeout();
    bit to;
    int d;
    int acc_cyc = -1;
    int fall_cyc = -1;
    int c = 0;
    rx.delete();
    owners.delete();
    rdy_pct = 100;
    q[3] = '{8'h55};
    q[0] = '{8'h30, 8'h31, 8'h0A};
    snapshot();
    build_model(3, 1'b1);
    drive();
    while (rx.size() < 4 && c < 400) begin
      step();
      c++;
      if (last_acc[3]) acc_cyc = cyc;
      if (acc_cyc >= 0 && fall_cyc < 0 && prev_locked && !locked) fall_cyc = cyc;
    end
    to = (rx.size() < 4);
    total++; if (to) begin bad++; $display("FAIL to_run: got %0d bytes want 4", rx.size()); end
    total++; if (fall_cyc - acc_cyc != 17) begin bad++; $display("FAIL to_release_delay: got %0d cycles want 17", fall_cyc - acc_cyc); end
    total++; if (owners.size() < 2 || owners[1] != 0) begin bad++; $display("FAIL to_next_owner: grants=%0d second=%0d want 0", owners.size(), (owners.size() > 1) ? owners[1] : -1); end
    d = first_diff();
    total++; if (d != -1) begin bad++; $display("FAIL to_stream: differs at %0d, got %0d bytes want %0d", d, rx.size(), exp_q.size()); end
    repeat (4) step();
  endtask

  task automatic test_no_lock();
    bit to;
    int d;
    sel = 1'b1;
    rx.delete();
    for (int i = 0; i < 4; i++) begin
      q[0].push_back(byte_t'($urandom_range(8'h20, 8'h7e)));
      q[1].push_back(byte_t'($urandom_range(8'h20, 8'h7e)));
    end
    snapshot();
    build_model(0, 1'b0);
    drive();
    run_until(8, 300, to);
    total++; if (to) begin bad++; $display("FAIL nolock_run: got %0d bytes want 8", rx.size()); end
    d = first_diff();
    total++; if (d != -1) begin bad++; $display("FAIL nolock_alternate: differs at %0d, got %0d bytes want %0d", d, rx.size(), exp_q.size()); end
    repeat (4) step();
    sel = 1'b0;
    drive();
  endtask

  task automatic test_stall();
    bit to;
    int d;
    int c = 0;
    byte_t held;
    rx.delete();
    q[0] = '{byte_t'($urandom_range(8'h20, 8'h7e)), byte_t'($urandom_range(8'h20, 8'h7e)), LF};
    snapshot();
    build_model(0, 1'b1);
    rdy_pct = 0;
    drive();
    while (!m_tx_valid && c < 50) begin
      step();
      c++;
    end
    total++; if (!m_tx_valid) begin bad++; $display("FAIL stall_load: tx_valid=%b want 1", m_tx_valid); end
    held = m_tx_data;
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if (m_tx_valid !== 1'b1 || m_tx_data !== held || m_ready !== 4'h0) begin
        bad++;
        $display("FAIL stall_hold: valid=%b data=%h ready=%h want 1/%h/0", m_tx_valid, m_tx_data, m_ready, held);
      end
    end
    total++; if (rx.size() != 0) begin bad++; $display("FAIL stall_leak: got %0d bytes want 0", rx.size()); end
    rdy_pct = 100;
    drive();
    step();
    total++; if (rx.size() != 1 || rx[0] !== held) begin bad++; $display("FAIL stall_release: got %0d bytes want 1 of %h", rx.size(), held); end
    run_until(3, 100, to);
    d = first_diff();
    total++; if (to || d != -1) begin bad++; $display("FAIL stall_stream: differs at %0d, got %0d bytes want %0d", d, rx.size(), exp_q.size()); end
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    bit to;
    int d;
    int c = 0;
    rx.delete();
    owners.delete();
    for (int i = 0; i < 3; i++) q[0].push_back(byte_t'($urandom_range(8'h20, 8'h7e)));
    q[0].push_back(LF);
    rdy_pct = 0;
    drive();
    while (!m_tx_valid && c < 50) begin
      step();
      c++;
    end
    total++; if (!m_tx_valid) begin bad++; $display("FAIL rstmid_load: tx_valid=%b want 1", m_tx_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (m_tx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_tx_valid: got %b want 0", m_tx_valid); end
    total++; if (m_locked !== 1'b0) begin bad++; $display("FAIL rstmid_locked: got %b want 0", m_locked); end
    total++; if (m_ready !== 4'h0) begin bad++; $display("FAIL rstmid_ready: got %h want 0", m_ready); end
    q[2] = '{byte_t'($urandom_range(8'h20, 8'h7e)), LF};
    snapshot();
    build_model(0, 1'b1);
    rdy_pct = 100;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_until(exp_q.size(), 300, to);
    total++; if (owners.size() == 0 || owners[0] != 0) begin bad++; $display("FAIL rstmid_first_owner: grants=%0d first=%0d want 0", owners.size(), (owners.size() > 0) ? owners[0] : -1); end
    d = first_diff();
    total++; if (to || d != -1) begin bad++; $display("FAIL rstmid_stream: differs at %0d, got %0d bytes want %0d", d, rx.size(), exp_q.size()); end
    repeat (4) step();
  endtask

  task automatic test_random();
    bit to;
    int d;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < NR; k++) q[k].delete();
      rdy_pct = 100;
      do_reset();
      for (int k = 0; k < NR; k++) begin
        int n = $urandom_range(0, 6);
        for (int i = 0; i < n; i++)
          q[k].push_back(($urandom_range(0, 3) == 0) ? LF : byte_t'($urandom_range(8'h20, 8'h7e)));
      end
      snapshot();
      build_model(0, 1'b1);
      rx.delete();
      rdy_pct = 50;
      drive();
      run_until(exp_q.size(), 2000, to);
      d = first_diff();
      total++;
      if (to || d != -1) begin
        bad++;
        $display("FAIL random_%0d: differs at %0d, got %0d bytes want %0d", it, d, rx.size(), exp_q.size());
      end
    end
    rdy_pct = 100;
    repeat (4) step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rdy_pct = 100;
    last_acc = '0;
    prev_locked = 1'b0;
    test_reset();
    test_hi();
    test_two_lines();
    test_timeout();
    test_no_lock();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
